rv32_multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences fetch/decode/execute/memory/writeback

---
 rtl/rv32_ctrl_pkg.sv | 103 ++++++++++
 rtl/rv32_opcode_class.sv | 36 +++
 rtl/rv32_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg
//   Shared definitions for the RV32I multi-cycle controller and its datapath.
//   Contents:
//     - RV32I base opcodes (IR[6:0])
//     - controller state encoding; ST_TRAP exists only when ILLEGAL_TRAP_EN is defined
//     - mux and format encodings for imm_sel, alu_src_a, alu_src_b, alu_op and wb_sel.
//       The immediate generator and the datapath muxes decode these same values.
//     - insn_class_t, a one-hot instruction class produced by rv32_opcode_class
//     - imm_format(), which maps an instruction class to its immediate format
//   Build macro: ILLEGAL_TRAP_EN adds the TRAP state.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

`ifdef ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;
`endif

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'd0,
        SRC_A_PC   = 2'd1,
        SRC_A_ZERO = 2'd2
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'd0,
        SRC_B_IMM  = 2'd1,
        SRC_B_FOUR = 2'd2
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_CMP   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

    // FENCE and SYSTEM are legal but have no class bit; they retire as no-ops.
    typedef struct packed {
        logic is_lui;
        logic is_auipc;
        logic is_jal;
        logic is_jalr;
        logic is_branch;
        logic is_load;
        logic is_store;
        logic is_op_imm;
        logic is_op;
    } insn_class_t;

    function automatic logic [2:0] imm_format(input insn_class_t c);
        if (c.is_store) begin
            return IMM_S;
        end else if (c.is_branch) begin
            return IMM_B;
        end else if (c.is_lui || c.is_auipc) begin
            return IMM_U;
        end else if (c.is_jal) begin
            return IMM_J;
        end else begin
            return IMM_I;
        end
    endfunction

endpackage

// File: rtl/rv32_opcode_class.sv
// rv32_opcode_class
//   Combinational classifier that turns IR[6:0] into a one-hot instruction class
//   and a flag saying whether the opcode belongs to the RV32I base set.
//   Ports:
//     opcode  in   7    IR[6:0]
//     cls     out  insn_class_t  one-hot class; all zero for FENCE, SYSTEM and illegal opcodes
//     legal   out  1    opcode is in the RV32I base set
module rv32_opcode_class
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output insn_class_t cls,
    output logic        legal
);

    // Opcode lookup.
    always_comb begin
        cls   = '0;
        legal = 1'b1;
        case (opcode)
            OPC_LUI:      cls.is_lui    = 1'b1;
            OPC_AUIPC:    cls.is_auipc  = 1'b1;
            OPC_JAL:      cls.is_jal    = 1'b1;
            OPC_JALR:     cls.is_jalr   = 1'b1;
            OPC_BRANCH:   cls.is_branch = 1'b1;
            OPC_LOAD:     cls.is_load   = 1'b1;
            OPC_STORE:    cls.is_store  = 1'b1;
            OPC_OP_IMM:   cls.is_op_imm = 1'b1;
            OPC_OP:       cls.is_op     = 1'b1;
            OPC_MISC_MEM: legal         = 1'b1;
            OPC_SYSTEM:   legal         = 1'b1;
            default:      legal         = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl
//   Multi-cycle control FSM for an RV32I core. It steps each instruction through
//   FETCH, DECODE, EXEC, MEM and WB over one shared memory port and a single ALU.
//   It drives the immediate-format select, the ALU and writeback muxes, and the
//   PC, IR and register write strobes.
//
//   Parameters:
//     MAX_WAIT  cycles mem_req may wait for mem_ready before mem_err; 0 disables the timeout
//     WAIT_W    wait-counter width; 2**WAIT_W must exceed MAX_WAIT
//
//   Ports:
//     clk, rst (synchronous, active-high)
//     Inputs:
//       instruction   IR contents
//       mem_ready     memory acknowledge
//       branch_taken  ALU compare result
//     Outputs:
//       mem_req, mem_we, addr_sel   memory request, direction and address select
//       ir_write, pc_write, pc_src  IR and PC update strobes, PC source select
//       reg_write                   register-file write enable
//       imm_sel                     immediate format
//       alu_src_a, alu_src_b        ALU operand selects
//       alu_op                      ALU operation
//       wb_sel                      writeback source select
//       mem_err                     one-cycle pulse on memory timeout
//       illegal_insn                sticky flag, set in TRAP
//
//   Build macro ILLEGAL_TRAP_EN: an opcode outside the base set moves DECODE into
//   TRAP, which holds until rst. When the macro is undefined, such opcodes retire
//   as no-ops and illegal_insn stays 0.
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic [2:0]  imm_sel,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        mem_err,
    output logic        illegal_insn
);

    localparam bit              TIMEOUT_EN = (MAX_WAIT != 0);
    // The timeout fires on the cycle the count would reach MAX_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = TIMEOUT_EN ? WAIT_W'(MAX_WAIT - 1) : '0;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    insn_class_t       cls;
    logic              insn_legal;
    logic              wait_hit;
    logic [2:0]        imm_fmt;
    logic              unused_ir_bits;

    rv32_opcode_class u_class (
        .opcode (instruction[6:0]),
        .cls    (cls),
        .legal  (insn_legal)
    );

    // Only the opcode field steers the controller.
    assign unused_ir_bits = ^{instruction[31:7], insn_legal};
    assign imm_fmt        = imm_format(cls);
    assign wait_hit       = TIMEOUT_EN && (wait_q == WAIT_LAST);

    // Next-state, output decode and wait-counter update.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        reg_write    = 1'b0;
        imm_sel      = IMM_I;
        alu_src_a    = SRC_A_RS1;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        wb_sel       = WB_ALU;
        mem_err      = 1'b0;
        illegal_insn = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_hit) begin
                    // Nothing is written, so the retry fetches the same PC.
                    mem_err = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                // Precompute the branch/jump target old_pc + imm.
                imm_sel   = imm_fmt;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_IMM;
`ifdef ILLEGAL_TRAP_EN
                if (insn_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                end
`else
                state_d = ST_EXEC;
`endif
            end
            ST_EXEC: begin
                imm_sel = imm_fmt;
                state_d = ST_FETCH;
                if (cls.is_op || cls.is_op_imm) begin
                    alu_op    = ALU_FUNCT;
                    alu_src_b = cls.is_op_imm ? SRC_B_IMM : SRC_B_RS2;
                    state_d   = ST_WB;
                end else if (cls.is_lui || cls.is_auipc) begin
                    alu_src_a = cls.is_lui ? SRC_A_ZERO : SRC_A_PC;
                    alu_src_b = SRC_B_IMM;
                    state_d   = ST_WB;
                end else if (cls.is_load || cls.is_store) begin
                    alu_src_b = SRC_B_IMM;
                    state_d   = ST_MEM;
                end else if (cls.is_branch) begin
                    alu_op = ALU_CMP;
                    if (branch_taken) begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end else begin
                        pc_write = 1'b0;
                    end
                end else if (cls.is_jal || cls.is_jalr) begin
                    // Link and redirect in the same cycle. The ALU recomputes the target.
                    alu_src_a = cls.is_jal ? SRC_A_PC : SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    reg_write = 1'b1;
                    wb_sel    = WB_PC;
                    pc_write  = 1'b1;
                    pc_src    = 1'b1;
                end else begin
                    // FENCE, SYSTEM and unrecognised opcodes retire with no writes.
                    state_d = ST_FETCH;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = cls.is_store;
                imm_sel  = imm_fmt;
                if (mem_ready) begin
                    state_d = cls.is_load ? ST_WB : ST_FETCH;
                end else if (wait_hit) begin
                    mem_err = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = cls.is_load ? WB_MEM : WB_ALU;
                imm_sel   = imm_fmt;
                state_d   = ST_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: begin
                illegal_insn = 1'b1;
                state_d      = ST_TRAP;
            end
`endif
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (rst) begin
            // Drop any access in flight and hold every output low this cycle.
            state_d      = ST_FETCH;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            addr_sel     = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = 1'b0;
            reg_write    = 1'b0;
            imm_sel      = IMM_I;
            alu_src_a    = SRC_A_RS1;
            alu_src_b    = SRC_B_RS2;
            alu_op       = ALU_ADD;
            wb_sel       = WB_ALU;
            mem_err      = 1'b0;
            illegal_insn = 1'b0;
        end else begin
            illegal_insn = illegal_insn;
        end

        // The wait counter restarts on every state change and after a timeout.
        if (rst || (state_d != state_q) || mem_err) begin
            wait_d = '0;
        end else if (mem_req && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl
//   Randomized, self-checking bench for rv32_multicycle_ctrl with MAX_WAIT=4.
//   For each instruction the bench expands its class and the memory-wait
//   schedule into the expected per-cycle outputs. It then drives that schedule
//   and compares the DUT outputs on every cycle.
module tb_rv32_multicycle_ctrl;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = 32'h0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write;
    logic [2:0]  imm_sel;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, wb_sel;
    logic        mem_err, illegal_insn;

    int n_checks = 0;
    int n_errors = 0;
    int n_cycle  = 0;

    rv32_multicycle_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .imm_sel      (imm_sel),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .wb_sel       (wb_sel),
        .mem_err      (mem_err),
        .illegal_insn (illegal_insn)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus together with the outputs expected in that cycle.
    typedef struct packed {
        logic [31:0] insn;
        logic        rst, rdy, bt;
        logic        mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write;
        logic        mem_err, illegal;
        logic [2:0]  imm;
        logic [1:0]  a, b, op, wb;
    } cyc_t;

    cyc_t q[$];

    logic [6:0] opcs [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                              7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F, 7'h00};

    function automatic logic [2:0] imm_fmt(input logic [6:0] opc);
        case (opc)
            7'h23:        return 3'd1;
            7'h63:        return 3'd2;
            7'h37, 7'h17: return 3'd3;
            7'h6F:        return 3'd4;
            default:      return 3'd0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                           7'h13, 7'h33, 7'h0F, 7'h73};
    endfunction

    // A quiet cycle: all outputs low, and the inputs that should be ignored are random.
    function automatic cyc_t base(input logic [31:0] insn);
        cyc_t c;
        c      = '0;
        c.insn = insn;
        c.rdy  = 1'($urandom_range(0, 1));
        c.bt   = 1'($urandom_range(0, 1));
        return c;
    endfunction

    function automatic cyc_t mem_wait(input logic [31:0] insn, input logic in_mem,
                                      input logic we, input logic [2:0] fmt);
        cyc_t c;
        c          = base(insn);
        c.rdy      = 1'b0;
        c.mem_req  = 1'b1;
        c.addr_sel = in_mem;
        c.mem_we   = we;
        c.imm      = fmt;
        return c;
    endfunction

    // Expands one instruction into its expected cycles and appends them to q.
    //   fw/mw: number of wait cycles before mem_ready in the fetch / memory phase.
    //          -1 means random. A value >= MAX_WAIT times out.
    //   cut:   truncate after this many cycles and insert a reset cycle.
    //          -1 means no reset, -2 means a random occasional reset.
    // Returns the number of cycles before any inserted reset.
    function automatic int plan_insn(input logic [31:0] insn, input int fw, input int mw,
                                     input logic bt, input int cut);
        cyc_t       p[$];
        cyc_t       c;
        logic [6:0] opc;
        logic [2:0] fmt;
        int         w, tries, len, cut_at;
        bit         done;
        opc   = insn[6:0];
        fmt   = imm_fmt(opc);
        w     = fw;
        tries = 0;
        done  = 1'b0;
        while (!done) begin
            if (w < 0) w = (tries < 2) ? int'($urandom_range(0, 5))
                                       : int'($urandom_range(0, MAX_WAIT - 1));
            for (int i = 0; i < w && i < MAX_WAIT - 1; i++)
                p.push_back(mem_wait(insn, 1'b0, 1'b0, 3'd0));
            c = mem_wait(insn, 1'b0, 1'b0, 3'd0);
            if (w < MAX_WAIT) begin
                c.rdy = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1; done = 1'b1;
            end else begin
                c.mem_err = 1'b1;
            end
            p.push_back(c);
            tries++;
            w = -1;
        end
        c = base(insn); c.imm = fmt; c.a = 2'd1; c.b = 2'd1;
        p.push_back(c);
`ifdef ILLEGAL_TRAP_EN
        if (!is_legal(opc)) begin
            for (int i = 0; i < 3; i++) begin
                c = base(insn); c.illegal = 1'b1; p.push_back(c);
            end
            len = p.size();
            c = base(insn); c.rst = 1'b1; p.push_back(c);
            foreach (p[i]) q.push_back(p[i]);
            return len;
        end
`endif
        c = base(insn); c.imm = fmt; c.bt = bt;
        case (opc)
            7'h33: c.op = 2'd2;
            7'h13: begin c.b = 2'd1; c.op = 2'd2; end
            7'h37: begin c.a = 2'd2; c.b = 2'd1; end
            7'h17: begin c.a = 2'd1; c.b = 2'd1; end
            7'h03, 7'h23: c.b = 2'd1;
            7'h63: begin c.op = 2'd1; c.pc_write = bt; c.pc_src = bt; end
            7'h6F, 7'h67: begin
                c.a = (opc == 7'h6F) ? 2'd1 : 2'd0; c.b = 2'd1;
                c.reg_write = 1'b1; c.wb = 2'd2; c.pc_write = 1'b1; c.pc_src = 1'b1;
            end
            default: c.op = 2'd0;
        endcase
        p.push_back(c);
        if (opc == 7'h03 || opc == 7'h23) begin
            w = (mw < 0) ? int'($urandom_range(0, 5)) : mw;
            for (int i = 0; i < w && i < MAX_WAIT - 1; i++)
                p.push_back(mem_wait(insn, 1'b1, opc == 7'h23, fmt));
            c = mem_wait(insn, 1'b1, opc == 7'h23, fmt);
            if (w < MAX_WAIT) begin
                c.rdy = 1'b1;
                p.push_back(c);
                if (opc == 7'h03) begin
                    c = base(insn); c.imm = fmt; c.reg_write = 1'b1; c.wb = 2'd1;
                    p.push_back(c);
                end
            end else begin
                c.mem_err = 1'b1;
                p.push_back(c);
            end
        end else if (opc inside {7'h33, 7'h13, 7'h37, 7'h17}) begin
            c = base(insn); c.imm = fmt; c.reg_write = 1'b1;
            p.push_back(c);
        end
        len    = p.size();
        cut_at = cut;
        if (cut_at == -2)
            cut_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        if (cut_at >= 0 && cut_at < len) begin
            while (p.size() > cut_at) void'(p.pop_back());
            c = base(insn); c.rst = 1'b1; p.push_back(c);
        end
        foreach (p[i]) q.push_back(p[i]);
        return len;
    endfunction

    task automatic pin(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Drives every planned cycle and compares the outputs at mid-cycle.
    task automatic run_q();
        cyc_t       c;
        logic [19:0] got, exp;
        while (q.size() > 0) begin
            c            = q.pop_front();
            rst          = c.rst;
            mem_ready    = c.rdy;
            branch_taken = c.bt;
            instruction  = c.insn;
            @(negedge clk);
            got = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, reg_write,
                   mem_err, illegal_insn, imm_sel, alu_src_a, alu_src_b, alu_op, wb_sel};
            exp = {c.mem_req, c.mem_we, c.addr_sel, c.ir_write, c.pc_write, c.pc_src,
                   c.reg_write, c.mem_err, c.illegal, c.imm, c.a, c.b, c.op, c.wb};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL outputs cyc=%0d insn=%h rst=%b rdy=%b bt=%b got=%b exp=%b",
                         n_cycle, c.insn, c.rst, c.rdy, c.bt, got, exp);
            end
            n_cycle++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc_t       c;
        logic [31:0] insn;
        for (int i = 0; i < 2; i++) begin
            c = base(32'h0); c.rst = 1'b1; q.push_back(c);
        end
        pin("len_addi",     plan_insn(32'h00500093, 0, 0, 1'b0, -1), 4);
        pin("len_lw_wait3", plan_insn(32'h0000A103, 0, 3, 1'b0, -1), 8);
        pin("len_sw",       plan_insn(32'h0020A023, 0, 0, 1'b0, -1), 4);
        pin("len_beq_t",    plan_insn(32'h00208463, 0, 0, 1'b1, -1), 3);
        pin("len_beq_nt",   plan_insn(32'h00208463, 0, 0, 1'b0, -1), 3);
        pin("len_jal",      plan_insn(32'h008000EF, 0, 0, 1'b0, -1), 3);
        pin("len_fetch_w3", plan_insn(32'h00500093, 3, 0, 1'b0, -1), 7);
        void'(plan_insn(32'h00500093, MAX_WAIT, 0, 1'b0, -1));
        void'(plan_insn(32'h0000A103, 0, 3, 1'b0, 4));
`ifdef ILLEGAL_TRAP_EN
        pin("len_illegal", plan_insn(32'h0000007F, 0, 0, 1'b0, -1), 5);
`else
        pin("len_illegal", plan_insn(32'h0000007F, 0, 0, 1'b0, -1), 3);
`endif
        void'(plan_insn(32'h0000A103, 0, MAX_WAIT, 1'b0, -1));
        run_q();
        for (int n = 0; n < 400; n++) begin
            insn      = $urandom;
            insn[6:0] = opcs[$urandom_range(0, 12)];
            void'(plan_insn(insn, -1, -1, 1'($urandom_range(0, 1)), -2));
        end
        run_q();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
